// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: state encoding, function
// select codes, golden tables and small checker helpers.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CHK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int FSEL_FA = 0;
  localparam int FSEL_FB = 1;
  localparam int FSEL_FC = 2;
  localparam int FSEL_FD = 3;
  localparam int FSEL_FE = 4;

  // Golden truth tables, bit i = f(w,x,y,z) with i = {w,x,y,z}
  localparam logic [15:0] TT_FA = 16'hE2E2;
  localparam logic [15:0] TT_FB = 16'hE4E4;
  localparam logic [15:0] TT_FC = 16'h88CE;
  localparam logic [15:0] TT_FD = 16'h5546;
  localparam logic [15:0] TT_FE = 16'h09A5;

  // Number of set bits in a 16-bit word; 5 bits so that 16 fits
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

  // Index of the lowest set bit; 0 when no bit is set
  function automatic logic [3:0] lowest_set16(input logic [15:0] v);
    logic [3:0] pos;
    pos = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) pos = 4'(i);
    end
    return pos;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_func_bank.sv
// Combinational bank of the five sum-of-products functions fa..fe, evaluated
// on vec = {w,x,y,z}; one output is selected by func_sel, invalid selects give 0.
module truth_table_sweeper_func_bank
  import truth_table_sweeper_pkg::*;
#(
  parameter int NUM_FUNCS = 5,
  parameter int SEL_W     = 3
) (
  input  logic [3:0]       vec,
  input  logic [SEL_W-1:0] func_sel,
  output logic             f
);

  logic w, x, y, z;
  logic fa, fb, fc, fd, fe;

  assign w = vec[3];
  assign x = vec[2];
  assign y = vec[1];
  assign z = vec[0];

  assign fa = (~y & z) | (x & y);
  assign fb = (y & ~z) | (x & z);
  assign fc = (y & z) | (~w & y) | (~w & ~x & z);
  assign fd = (w & ~z) | (~w & y & ~z) | (~w & ~x & ~y & z);
  assign fe = (~w & ~x & ~z) | (~w & x & z) | (w & ~x & ~y & ~z) | (w & ~x & y & z);

  // Select one function output; anything outside the bank reads as 0
  always_comb begin
    f = 1'b0;
    if (int'(func_sel) < NUM_FUNCS) begin
      case (func_sel)
        SEL_W'(FSEL_FA): f = fa;
        SEL_W'(FSEL_FB): f = fb;
        SEL_W'(FSEL_FC): f = fc;
        SEL_W'(FSEL_FD): f = fd;
        SEL_W'(FSEL_FE): f = fe;
        default:         f = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps the selected bank function through all 16 minterms, captures the
// resulting truth table and compares it against a caller-supplied table.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int NUM_FUNCS = 5,
  parameter int SEL_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEL_W-1:0] func_sel,
  input  logic [15:0]      expected,
  output logic [3:0]       vec,
  output logic             busy,
  output logic             done,
  output logic [15:0]      table_out,
  output logic             mismatch,
  output logic [4:0]       err_cnt,
  output logic [3:0]       first_err
);

  state_t           state, state_next;
  logic [3:0]       idx;
  logic [SEL_W-1:0] sel_lat;
  logic [15:0]      exp_lat;
  logic             bank_out;
  logic             accept;

  assign accept = (state == ST_IDLE) && start;

  // Stimulus is the registered index while running, parked at 0 otherwise
  assign vec  = (state == ST_RUN) ? idx : 4'd0;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  truth_table_sweeper_func_bank #(
    .NUM_FUNCS (NUM_FUNCS),
    .SEL_W     (SEL_W)
  ) u_func_bank (
    .vec      (vec),
    .func_sel (sel_lat),
    .f        (bank_out)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: IDLE -> RUN (16 cycles) -> CHK -> DONE -> IDLE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (idx == 4'd15) state_next = ST_CHK;
      ST_CHK:  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Latch the request, capture one table bit per RUN cycle, then register the check
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= 4'd0;
      sel_lat   <= '0;
      exp_lat   <= 16'd0;
      table_out <= 16'd0;
      mismatch  <= 1'b0;
      err_cnt   <= 5'd0;
      first_err <= 4'd0;
    end else begin
      if (accept) begin
        sel_lat   <= func_sel;
        exp_lat   <= expected;
        idx       <= 4'd0;
        table_out <= 16'd0;
        mismatch  <= 1'b0;
        err_cnt   <= 5'd0;
        first_err <= 4'd0;
      end
      if (state == ST_RUN) begin
        table_out[idx] <= bank_out;
        // Hold at 15 on the last capture; the move to CHK ends the sweep
        if (idx != 4'd15) idx <= idx + 4'd1;
      end
      if (state == ST_CHK) begin
        mismatch  <= (table_out != exp_lat);
        err_cnt   <= popcount16(table_out ^ exp_lat);
        first_err <= lowest_set16(table_out ^ exp_lat);
      end
    end
  end

endmodule
